// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller and its queue.
package fetch_pkg;

  // Controller states: RUN issues fetches, FAULT stops issuing until an even redirect.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_e;

  // Byte distance between consecutive 16-bit instructions.
  localparam int PC_STEP = 2;

  // Number of fetched instructions buffered toward decode.
  localparam int FQ_DEPTH = 2;

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Bundle of the memory read port, redirect input and decode handshake.
// The controller is the master; memory, branch unit and decode form the slave side.
interface inst_fetch_ctrl_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_exc;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic                  fault;
  logic [ADDR_WIDTH-1:0] fault_pc;

  modport master (
    output mem_addr, out_valid, out_instr, out_pc, fault, fault_pc,
    input  mem_data, mem_exc, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  mem_addr, out_valid, out_instr, out_pc, fault, fault_pc,
    output mem_data, mem_exc, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry FIFO holding fetched {instr, pc} pairs between memory and decode.
// Push and pop may happen together; flush empties it without touching storage.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] pushInstr_i,
  input  logic [AW-1:0] pushPc_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [1:0]    count_o,
  output logic [DW-1:0] headInstr_o,
  output logic [AW-1:0] headPc_o
);

  logic [DW-1:0] instr_q [FQ_DEPTH];
  logic [AW-1:0] pc_q    [FQ_DEPTH];
  logic          rdPtr_q;
  logic          wrPtr_q;
  logic [1:0]    count_q;
  logic [1:0]    count_d;
  logic          doPush;
  logic          doPop;

  // A push is accepted when there is room, or when a pop frees the head slot.
  always_comb begin
    doPop   = pop_i && (count_q != 2'd0);
    doPush  = push_i && ((count_q < 2'(FQ_DEPTH)) || doPop);
    count_d = count_q + {1'b0, doPush} - {1'b0, doPop};
  end

  // Storage and pointers; reset clears the entries so the head reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FQ_DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
      rdPtr_q <= 1'b0;
      wrPtr_q <= 1'b0;
      count_q <= 2'd0;
    end else if (flush_i) begin
      rdPtr_q <= 1'b0;
      wrPtr_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (doPush) begin
        instr_q[wrPtr_q] <= pushInstr_i;
        pc_q[wrPtr_q]    <= pushPc_i;
        wrPtr_q          <= ~wrPtr_q;
      end
      if (doPop) begin
        rdPtr_q <= ~rdPtr_q;
      end
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign headInstr_o = instr_q[rdPtr_q];
  assign headPc_o    = pc_q[rdPtr_q];

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, issues one aligned read per cycle,
// tracks the single in-flight response, buffers results and handles redirects/faults.
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_SIZE   = 4096,
  parameter int RESET_PC   = 0
) (
  input logic               clk,
  input logic               rst,
  inst_fetch_ctrl_if.master bus
);

  localparam logic [ADDR_WIDTH:0] PC_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE - 1);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflightPc_q, inflightPc_d;
  logic                  fault_q, fault_d;
  logic [ADDR_WIDTH-1:0] faultPc_q, faultPc_d;

  logic [1:0]            qCount;
  logic [DATA_WIDTH-1:0] headInstr;
  logic [ADDR_WIDTH-1:0] headPc;
  logic                  outValid;
  logic                  pop;
  logic                  push;
  logic                  flush;
  logic [2:0]            occupancy;

  fetch_queue #(
    .AW(ADDR_WIDTH),
    .DW(DATA_WIDTH)
  ) uQueue (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .pushInstr_i(bus.mem_data),
    .pushPc_i   (inflightPc_q),
    .pop_i      (pop),
    .flush_i    (flush),
    .count_o    (qCount),
    .headInstr_o(headInstr),
    .headPc_o   (headPc)
  );

  // Handshake toward decode; a redirect hides the head so nothing stale is consumed.
  always_comb begin
    outValid  = (qCount != 2'd0) && !bus.redirect_valid;
    pop       = outValid && bus.out_ready;
    occupancy = {1'b0, qCount} + {2'b00, inflight_q} - {2'b00, pop};
  end

  // Next-state logic: redirect wins, then response handling, then issue or pre-check fault.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inflight_d   = 1'b0;
    inflightPc_d = inflightPc_q;
    fault_d      = fault_q;
    faultPc_d    = faultPc_q;
    push         = 1'b0;
    flush        = 1'b0;

    if (bus.redirect_valid) begin
      flush = 1'b1;
      pc_d  = bus.redirect_pc;
      if (bus.redirect_pc[0]) begin
        state_d   = ST_FAULT;
        fault_d   = 1'b1;
        faultPc_d = bus.redirect_pc;
      end else begin
        state_d = ST_RUN;
        fault_d = 1'b0;
      end
    end else if (inflight_q && bus.mem_exc) begin
      state_d   = ST_FAULT;
      fault_d   = 1'b1;
      faultPc_d = inflightPc_q;
    end else begin
      push = inflight_q;
      if (state_q == ST_RUN) begin
        if ({1'b0, pc_q} >= PC_LIMIT) begin
          state_d   = ST_FAULT;
          fault_d   = 1'b1;
          faultPc_d = pc_q;
        end else if (occupancy < 3'(FQ_DEPTH)) begin
          inflight_d   = 1'b1;
          inflightPc_d = pc_q;
          pc_d         = pc_q + ADDR_WIDTH'(PC_STEP);
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      pc_q         <= ADDR_WIDTH'(RESET_PC);
      inflight_q   <= 1'b0;
      inflightPc_q <= '0;
      fault_q      <= 1'b0;
      faultPc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      inflightPc_q <= inflightPc_d;
      fault_q      <= fault_d;
      faultPc_q    <= faultPc_d;
    end
  end

  assign bus.mem_addr  = pc_q;
  assign bus.out_valid = outValid;
  assign bus.out_instr = headInstr;
  assign bus.out_pc    = headPc;
  assign bus.fault     = fault_q;
  assign bus.fault_pc  = faultPc_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Testbench for inst_fetch_ctrl: models the instruction memory and checks the
// delivered stream against a sequential-PC reference plus directed timing points.
module tb_inst_fetch_ctrl;

  localparam int AW       = 16;
  localparam int DW       = 16;
  localparam int MEM_SIZE = 4096;
  localparam int RESET_PC = 0;

  logic clk = 1'b0;
  logic rst;

  inst_fetch_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  inst_fetch_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MEM_SIZE  (MEM_SIZE),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] memArr [MEM_SIZE/2];
  logic          forceExcEn = 1'b0;
  logic [AW-1:0] forceExcAddr = '0;
  logic [AW-1:0] expPc = '0;
  int            transfers = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  // Memory content: three fixed words at the start, a scrambled pattern elsewhere.
  function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
    case (a)
      16'd0:   return 16'h1111;
      16'd2:   return 16'h2222;
      16'd4:   return 16'h3333;
      default: return 16'(a * 16'h9E37) ^ 16'h5A5A;
    endcase
  endfunction

  // Synchronous-read memory with one-cycle latency and range/forced exceptions.
  always @(posedge clk) begin
    bus.mem_data <= memArr[bus.mem_addr[11:1]];
    bus.mem_exc  <= (bus.mem_addr >= AW'(MEM_SIZE - 1)) ||
                    (forceExcEn && (bus.mem_addr == forceExcAddr));
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs, then check any transfer against the reference stream.
  task automatic applyStimulus(input logic r, input logic rv, input logic [AW-1:0] rpc,
                               input logic rdy);
    rst                = r;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.out_ready      = rdy;
    #1;
    if (!r) begin
      if (rv) begin
        checkOutput("redirect_hides_valid", 32'(bus.out_valid), 32'd0);
      end else if (bus.out_valid && bus.out_ready) begin
        checkOutput("stream_pc", 32'(bus.out_pc), 32'(expPc));
        checkOutput("stream_instr", 32'(bus.out_instr), 32'(memWord(expPc)));
        expPc = expPc + 16'd2;
        transfers++;
      end
    end
    if (r) expPc = AW'(RESET_PC);
    else if (rv) expPc = rpc;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_fault", 32'(bus.fault), 32'd0);
    checkOutput("rst_fault_pc", 32'(bus.fault_pc), 32'd0);
    checkOutput("rst_out_pc", 32'(bus.out_pc), 32'd0);
    checkOutput("rst_out_instr", 32'(bus.out_instr), 32'd0);
    checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'(RESET_PC));
  endtask

  // Stream up to 4094, force an exception there; optionally reset while faulted.
  task automatic faultScenario(input bit withReset);
    forceExcEn   = 1'b1;
    forceExcAddr = 16'd4094;
    applyStimulus(1'b0, 1'b1, 16'd4088, 1'b1);
    nextCycle();
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0, 1'b0, 16'd0, 1'b1);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 16'd0, 1'b0);
    checkOutput("exc_cycle_no_fault_yet", 32'(bus.fault), 32'd0);
    nextCycle();
    applyStimulus(withReset, 1'b0, 16'd0, 1'b0);
    checkOutput("exc_fault", 32'(bus.fault), 32'd1);
    checkOutput("exc_fault_pc", 32'(bus.fault_pc), 32'd4094);
    checkOutput("exc_queued_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("exc_queued_pc", 32'(bus.out_pc), 32'd4092);
    nextCycle();
    forceExcEn = 1'b0;
    if (withReset) begin
      applyStimulus(1'b0, 1'b0, 16'd0, 1'b1);
      checkResetOutputs();
      nextCycle();
      for (int c = 1; c <= 2; c++) begin
        applyStimulus(1'b0, 1'b0, 16'd0, 1'b1);
        if (c == 2) begin
          checkOutput("restart_valid", 32'(bus.out_valid), 32'd1);
          checkOutput("restart_pc", 32'(bus.out_pc), 32'(RESET_PC));
        end
        nextCycle();
      end
    end else begin
      applyStimulus(1'b0, 1'b0, 16'd0, 1'b1);
      checkOutput("drain_done", 32'(expPc), 32'd4094);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 16'd0, 1'b1);
      checkOutput("fault_empty", 32'(bus.out_valid), 32'd0);
      checkOutput("fault_sticky", 32'(bus.fault), 32'd1);
      checkOutput("fault_addr_frozen", 32'(bus.mem_addr), 32'd4096);
      nextCycle();
    end
  endtask

  initial begin
    int readyPattern [6];
    int readyCount;
    logic [AW-1:0] target;

    readyPattern = '{1, 0, 0, 1, 0, 1};
    for (int i = 0; i < MEM_SIZE / 2; i++) memArr[i] = memWord(AW'(2 * i));
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b1;

    // Reset state after one clock edge in reset.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 16'd0, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 16'd0, 1'b1);
    checkResetOutputs();
    nextCycle();

    // First delivery two cycles after reset release, then back to back.
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 1'b0, 16'd0, 1'b1);
      if (c < 2) checkOutput("first_valid_early", 32'(bus.out_valid), 32'd0);
      if (c == 2) begin
        checkOutput("first_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("first_instr", 32'(bus.out_instr), 32'h1111);
        checkOutput("first_pc", 32'(bus.out_pc), 32'd0);
      end
      if (c == 3) checkOutput("second_instr", 32'(bus.out_instr), 32'h2222);
      if (c == 4) checkOutput("third_instr", 32'(bus.out_instr), 32'h3333);
      nextCycle();
    end

    // Backpressure pattern: the queue never runs dry, so every ready cycle transfers.
    transfers  = 0;
    readyCount = 0;
    for (int c = 0; c < 18; c++) begin
      applyStimulus(1'b0, 1'b0, 16'd0, 1'(readyPattern[c % 6]));
      readyCount += readyPattern[c % 6];
      nextCycle();
    end
    checkOutput("pattern_transfers", 32'(transfers), 32'(readyCount));

    // Random ready with occasional even redirects.
    for (int c = 0; c < 80; c++) begin
      if ($urandom_range(0, 11) == 0) begin
        target = AW'(2 * $urandom_range(0, 1500));
        applyStimulus(1'b0, 1'b1, target, 1'($urandom_range(0, 1)));
      end else begin
        applyStimulus(1'b0, 1'b0, 16'd0, 1'($urandom_range(0, 1)));
      end
      nextCycle();
    end

    // Ready held high: one instruction per cycle after settling.
    for (int c = 0; c < 9; c++) begin
      applyStimulus(1'b0, 1'b0, 16'd0, 1'b1);
      if (c >= 3) checkOutput("no_bubble", 32'(bus.out_valid), 32'd1);
      nextCycle();
    end

    // Redirect with a full queue.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b0, 16'd0, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b1, 16'h0100, 1'b1);
    nextCycle();
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(1'b0, 1'b0, 16'd0, 1'b1);
      if (c < 3) checkOutput("redir_gap", 32'(bus.out_valid), 32'd0);
      else begin
        checkOutput("redir_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("redir_pc", 32'(bus.out_pc), 32'h0100);
      end
      nextCycle();
    end

    // Odd redirect faults and freezes the address; an even redirect recovers.
    applyStimulus(1'b0, 1'b1, 16'h0101, 1'b1);
    nextCycle();
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(1'b0, 1'b0, 16'd0, 1'b1);
      checkOutput("odd_fault", 32'(bus.fault), 32'd1);
      checkOutput("odd_fault_pc", 32'(bus.fault_pc), 32'h0101);
      checkOutput("odd_addr_frozen", 32'(bus.mem_addr), 32'h0101);
      checkOutput("odd_no_valid", 32'(bus.out_valid), 32'd0);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b1, 16'h0200, 1'b1);
    nextCycle();
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(1'b0, 1'b0, 16'd0, 1'b1);
      checkOutput("recover_fault", 32'(bus.fault), 32'd0);
      if (c == 3) checkOutput("recover_pc", 32'(bus.out_pc), 32'h0200);
      nextCycle();
    end

    // Exception at the top of memory, then the same with a reset while faulted.
    faultScenario(1'b0);
    faultScenario(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
